// File: rtl/preg_free_list.sv
// preg_free_list: circular free list of physical register IDs.
// Hands out up to two IDs per cycle and takes back up to two per cycle.
// Each branch tag can save a copy of the allocation head. Branch restore
// and flush move the head back, which returns speculative IDs to the list.
// Optional build macro FREELIST_DOUBLE_FREE_CHECK_EN: keeps a per-ID
// is_free bitmap, drops frees of IDs that are already free, and raises a
// sticky double_free flag when that happens.
module preg_free_list #(
    parameter int NUM_PREGS              = 64,
    parameter int NUM_AREGS              = 16,
    parameter int MAX_PREDICT_DEPTH      = 4,
    parameter int PW                     = $clog2(NUM_PREGS),
    parameter int MAX_PREDICT_DEPTH_BITS = $clog2(MAX_PREDICT_DEPTH + 1)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [1:0]                        alloc_req,
    output logic                              alloc_grant,
    output logic [PW-1:0]                     alloc_preg0,
    output logic [PW-1:0]                     alloc_preg1,
    input  logic [1:0]                        free_valid,
    input  logic [PW-1:0]                     free_preg0,
    input  logic [PW-1:0]                     free_preg1,
    input  logic [1:0]                        commit_num,
    input  logic                              checkpoint_valid,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] checkpoint_tag,
    input  logic                              restore_valid,
    input  logic [MAX_PREDICT_DEPTH_BITS-1:0] restore_tag,
    input  logic                              flush,
    output logic [PW:0]                       free_count,
    output logic                              double_free
);

    localparam int NFREE0 = NUM_PREGS - NUM_AREGS;
    typedef logic [PW:0] ptr_t;

    logic [PW-1:0]          r_list [NUM_PREGS];
    ptr_t                   r_head, r_tail, r_chead;
    ptr_t                   r_ck_head [MAX_PREDICT_DEPTH];
    logic [MAX_PREDICT_DEPTH-1:0] r_ck_vld;

    ptr_t                   w_free_count, w_head_alloc, w_head_nxt, w_tail_nxt;
    ptr_t                   w_rest_head, w_cnt_nxt;
    logic [PW-1:0]          w_head_p1, w_slot1_idx;
    logic                   w_req_ok, w_grant, w_rhit, w_acc0, w_acc1;
    logic [MAX_PREDICT_DEPTH-1:0] w_rsel, w_csel;

    assign w_free_count = r_tail - r_head;
    assign free_count   = w_free_count;
    assign w_req_ok     = (alloc_req == 2'd1) || (alloc_req == 2'd2);
    assign w_grant      = w_req_ok && (w_free_count >= {{(PW-1){1'b0}}, alloc_req})
                          && !flush && !restore_valid;
    assign alloc_grant  = w_grant;
    assign w_head_p1    = r_head[PW-1:0] + PW'(1);
    assign alloc_preg0  = r_list[r_head[PW-1:0]];
    assign alloc_preg1  = r_list[w_head_p1];
    assign w_head_alloc = r_head + (w_grant ? ptr_t'(alloc_req) : ptr_t'(0));

    // Decode restore / checkpoint tags into one-hot slot selects (tag 0 selects nothing)
    always_comb begin
        w_rsel      = '0;
        w_csel      = '0;
        w_rest_head = '0;
        for (int i = 0; i < MAX_PREDICT_DEPTH; i++) begin
            w_rsel[i] = restore_valid && (restore_tag == MAX_PREDICT_DEPTH_BITS'(i + 1));
            w_csel[i] = checkpoint_valid && (checkpoint_tag == MAX_PREDICT_DEPTH_BITS'(i + 1));
            if (w_rsel[i]) w_rest_head = r_ck_head[i];
        end
        w_rhit = |(w_rsel & r_ck_vld);
    end

    // Next head: flush beats restore beats normal allocation
    always_comb begin
        w_head_nxt = w_head_alloc;
        if (flush)       w_head_nxt = r_chead + ptr_t'(commit_num);
        else if (w_rhit) w_head_nxt = w_rest_head;
    end

`ifdef FREELIST_DOUBLE_FREE_CHECK_EN
    logic [NUM_PREGS-1:0] r_is_free, w_is_free_nxt;
    logic                 r_df;
    ptr_t                 w_dist;
    logic [PW-1:0]        w_idx;

    // A free is accepted only if the ID is not already free; a duplicate in slot 1 loses
    assign w_acc0 = free_valid[0] && !r_is_free[free_preg0];
    assign w_acc1 = free_valid[1] && !r_is_free[free_preg1] &&
                    !(free_valid[0] && (free_preg0 == free_preg1));

    // Bitmap update: allocations clear, rollback span and accepted frees set
    always_comb begin
        w_is_free_nxt = r_is_free;
        w_dist        = r_head - w_head_nxt;
        w_idx         = '0;
        if (w_grant) begin
            w_is_free_nxt[alloc_preg0] = 1'b0;
            if (alloc_req == 2'd2) w_is_free_nxt[alloc_preg1] = 1'b0;
        end
        if (flush || w_rhit) begin
            for (int k = 0; k < NUM_PREGS; k++) begin
                w_idx = w_head_nxt[PW-1:0] + PW'(k);
                if (ptr_t'(k) < w_dist) w_is_free_nxt[r_list[w_idx]] = 1'b1;
            end
        end
        if (w_acc0) w_is_free_nxt[free_preg0] = 1'b1;
        if (w_acc1) w_is_free_nxt[free_preg1] = 1'b1;
    end

    // Bitmap and sticky error flag registers
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PREGS; i++) r_is_free[i] <= (i >= NUM_AREGS);
            r_df <= 1'b0;
        end else begin
            r_is_free <= w_is_free_nxt;
            r_df      <= r_df | (free_valid[0] & ~w_acc0) | (free_valid[1] & ~w_acc1);
        end
    end
    assign double_free = r_df;
`else
    assign w_acc0      = free_valid[0];
    assign w_acc1      = free_valid[1];
    assign double_free = 1'b0;
`endif

    assign w_slot1_idx = r_tail[PW-1:0] + PW'(w_acc0);
    assign w_tail_nxt  = r_tail + ptr_t'(w_acc0) + ptr_t'(w_acc1);
    assign w_cnt_nxt   = w_tail_nxt - w_head_nxt;

    // List storage: reset to the unmapped IDs, then written at tail in slot order
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_PREGS; i++)
                r_list[i] <= (i < NFREE0) ? PW'(NUM_AREGS + i) : '0;
        end else begin
            if (w_acc0) r_list[r_tail[PW-1:0]] <= free_preg0;
            if (w_acc1) r_list[w_slot1_idx]    <= free_preg1;
        end
    end

    // Pointers and checkpoint slots
    always_ff @(posedge clk) begin
        if (reset) begin
            r_head   <= '0;
            r_chead  <= '0;
            r_tail   <= ptr_t'(NFREE0);
            r_ck_vld <= '0;
        end else begin
            r_head  <= w_head_nxt;
            r_tail  <= w_tail_nxt;
            r_chead <= r_chead + ptr_t'(commit_num);
            if (flush) begin
                r_ck_vld <= '0;
            end else if (restore_valid) begin
                if (w_rhit)
                    for (int i = 0; i < MAX_PREDICT_DEPTH; i++)
                        if ((i + 1) >= int'(restore_tag)) r_ck_vld[i] <= 1'b0;
            end else begin
                for (int i = 0; i < MAX_PREDICT_DEPTH; i++)
                    if (w_csel[i]) begin
                        r_ck_head[i] <= w_head_alloc;
                        r_ck_vld[i]  <= 1'b1;
                    end
            end
        end
    end

    // Returning more IDs than exist means the caller broke the protocol
    a_no_overfree: assert property (@(posedge clk) disable iff (reset)
        w_cnt_nxt <= ptr_t'(NUM_PREGS));

endmodule

// File: doc/preg_free_list.md
Name: preg_free_list

Overview:
Allocator for the physical register file. It keeps a circular list of free physical register IDs and supplies up to two IDs per cycle to the rename/ROB stage (preg1/preg2). It reclaims up to two IDs per cycle from commit (old mappings released). It also checkpoints and restores its allocation head per branch tag, so branch shootdown and pipeline flush return speculatively allocated registers to the list.

Parameters:
NUM_PREGS, 64, physical register count; must be a power of two and greater than NUM_AREGS
NUM_AREGS, 16, architectural register count; pregs 0..NUM_AREGS-1 are mapped at reset
MAX_PREDICT_DEPTH, 4, number of branch checkpoint slots; tags 1..MAX_PREDICT_DEPTH
PW (derived), $clog2(NUM_PREGS), width of a preg ID

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
alloc_req  in  2  number of pregs requested this cycle (0, 1 or 2; 3 is treated as 0)
alloc_grant  out  1  whole request granted this cycle
alloc_preg0  out  PW  first allocated ID
alloc_preg1  out  PW  second allocated ID
free_valid  in  2  bit i set: free_preg<i> is returned
free_preg0  in  PW  returned ID, slot 0
free_preg1  in  PW  returned ID, slot 1
commit_num  in  2  number of allocations retiring this cycle (0..2)
checkpoint_valid  in  1  save the allocation head for checkpoint_tag
checkpoint_tag  in  MAX_PREDICT_DEPTH_BITS  tag to save (1..MAX_PREDICT_DEPTH)
restore_valid  in  1  branch shootdown: roll back to restore_tag
restore_tag  in  MAX_PREDICT_DEPTH_BITS  tag to restore
flush  in  1  discard all speculative allocations
free_count  out  PW+1  number of free IDs
double_free  out  1  sticky error flag (see Optional Feature)

Behaviour:
- Storage: list[NUM_PREGS] of PW-bit IDs. Pointers head, tail and commit_head are PW+1 bits; the MSB is the wrap bit. free_count = tail - head.
- Reset: list[i] = NUM_AREGS+i for i < NUM_PREGS-NUM_AREGS. head = commit_head = 0. tail = NUM_PREGS-NUM_AREGS. All checkpoints invalid. double_free = 0.
- Outputs immediately after reset: free_count = NUM_PREGS-NUM_AREGS, alloc_preg0 = NUM_AREGS, alloc_preg1 = NUM_AREGS+1.
- Allocation is combinational, zero latency:
  - alloc_preg0 = list[head], alloc_preg1 = list[head+1].
  - alloc_grant = (alloc_req in 1..2) && free_count >= alloc_req && !flush && !restore_valid.
  - On grant, head += alloc_req at the clock edge. Requests are all-or-nothing: no partial grants.
- Free: each valid slot writes list[tail] in slot order (slot 0 first); tail advances by popcount(free_valid). Freed IDs become allocatable from the next cycle, never the same cycle.
- Commit: commit_head += commit_num every cycle, regardless of other events.
- Checkpoint: slot[tag-1] <= head after this cycle's grant, and the slot is marked valid. Tag 0 is ignored.
- Restore: if slot[restore_tag-1] is valid, head <= saved value. Slots for tags >= restore_tag are invalidated. Restore of an invalid or zero tag is a no-op except that alloc_grant is still forced to 0.
- Flush: head <= commit_head + commit_num; all checkpoints invalidated.
- Priority: reset > flush > restore > alloc. Frees and commit are applied in every cycle, including flush and restore cycles.
- A checkpoint in the same cycle as a flush or restore is dropped.
- Wrap-around: pointers wrap modulo 2*NUM_PREGS with no special case.
- Full/empty:
  - free_count == 0: grant = 0 for any nonzero request.
  - A free that would make free_count exceed NUM_PREGS is a protocol violation; the simulation assertion fires.

Optional Feature:
FREELIST_DOUBLE_FREE_CHECK_EN
- Defined: a NUM_PREGS-bit is_free bitmap is kept, reset to 1 for IDs >= NUM_AREGS.
  - Allocation clears the bit.
  - A free of an ID whose bit is already set is dropped: not written, tail not advanced. double_free sets and stays set until reset.
  - Both slots freeing the same ID in one cycle: slot 1 is dropped.
  - Restore and flush re-set the bits of IDs between the new head and the old head.
- Undefined: no bitmap; every free is accepted; double_free is tied to 0.

Test Plan:
- Reset, alloc_req=2 -> grant=1, pregs 16 and 17; next cycle free_count=46, alloc_preg0=18.
- Allocate 48 IDs (24 cycles of req=2) -> free_count=0; req=1 -> grant=0. Free 40 in the same cycle -> grant still 0 that cycle, 1 the next with preg 40.
- Checkpoint tag 1 after 2 allocs, alloc 4 more, restore_valid tag 1 -> free_count back to 46, alloc_preg0=18, tag 1 slot invalid.
- Alloc 6, commit_num=2, then flush -> head=2, free_count=46, alloc_preg0=18; alloc_req=2 during flush -> grant=0.
- Cycle 200 alloc/free pairs with random IDs -> pointers wrap; free_count constant; order of returned IDs is FIFO.
- With FREELIST_DOUBLE_FREE_CHECK_EN: free preg 20 while free -> double_free=1, free_count unchanged.
